// File: rtl/ee357_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encodings
// and requester port indices.
package ee357_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/ee357_rr_arb2.sv
// Two-way round-robin arbiter: picks a winner from req[1:0] and remembers
// the last-served port so that ties alternate between the requesters.
module ee357_rr_arb2
  import ee357_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant,
  output logic       grant_valid
);

  logic last_served;

  always_comb begin
    grant       = PORT_CPU;
    grant_valid = 1'b0;
    case (req)
      2'b01: begin
        grant       = PORT_CPU;
        grant_valid = 1'b1;
      end
      2'b10: begin
        grant       = PORT_DMA;
        grant_valid = 1'b1;
      end
      2'b11: begin
        grant       = (last_served == PORT_CPU) ? PORT_DMA : PORT_CPU;
        grant_valid = 1'b1;
      end
      default: begin
        grant       = PORT_CPU;
        grant_valid = 1'b0;
      end
    endcase
  end

  // Reset to the DMA port so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= PORT_DMA;
    end else if (update && grant_valid) begin
      last_served <= grant;
    end
  end

endmodule

// File: rtl/ee357_mem_arbiter.sv
// Shares one fixed-latency memory port between the CPU controller (port 0)
// and a DMA/loader master (port 1); returns a one-cycle ack and registered read data.
module ee357_mem_arbiter
  import ee357_mem_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          arb_grant;
  logic          arb_valid;

  ee357_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         ({req1, req0}),
    .update      (state == S_IDLE),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_valid) begin
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        gnt0   = (owner == PORT_CPU);
        gnt1   = (owner == PORT_DMA);
        if (cnt == '0) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        gnt0       = (owner == PORT_CPU);
        gnt1       = (owner == PORT_DMA);
        ack0       = (owner == PORT_CPU);
        ack1       = (owner == PORT_DMA);
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != S_IDLE);

  // The winner's command is latched at grant time so the memory side stays
  // stable even if the requester changes its inputs mid-access.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      owner     <= PORT_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            owner     <= arb_grant;
            lat_we    <= (arb_grant == PORT_DMA) ? we1 : we0;
            lat_addr  <= (arb_grant == PORT_DMA) ? addr1 : addr0;
            lat_wdata <= (arb_grant == PORT_DMA) ? wdata1 : wdata0;
            cnt       <= CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!lat_we) begin
            if (owner == PORT_CPU) begin
              rdata0 <= mem_rdata;
            end else begin
              rdata1 <= mem_rdata;
            end
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ee357_mem_arbiter.sv
// Directed bench for ee357_mem_arbiter with a queue of expected completions
// checked whenever an ack appears.
module tb_ee357_mem_arbiter;

  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int MEM_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0, ack0, gnt1, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   assert_count = 0;
  int   fail_count   = 0;
  int   cyc;

  ee357_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .ack0      (ack0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .ack1      (ack1),
    .rdata1    (rdata1),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data);
    exp_t e;
    if (port == 1'b0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end
    e.port = port;
    e.data = exp_data;
    sb.push_back(e);
  endtask

  task automatic waitAck(input int max_cycles, output int cycles);
    exp_t e;
    bit   seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < max_cycles) begin
      tick();
      cycles++;
      checkOutput("gnt_exclusive", {63'd0, gnt0 & gnt1}, 64'd0);
      if (ack0 || ack1) seen = 1'b1;
    end
    checkOutput("ack_seen", {63'd0, seen}, 64'd1);
    if (seen) begin
      checkOutput("ack_exclusive", {63'd0, ack0 & ack1}, 64'd0);
      checkOutput("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("ack_port", {63'd0, ack1}, {63'd0, e.port});
        checkOutput("rdata", e.port ? rdata1 : rdata0, e.data);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_gnt", {gnt0, gnt1}, 0);
    checkOutput("rst_ack", {ack0, ack1}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_rdata", {rdata0, rdata1}, 0);
    rst = 1'b0;
    tick();

    // Single read on port 0
    applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    tick();
    checkOutput("t1_mem_en_c1", mem_en, 1);
    checkOutput("t1_mem_addr_c1", mem_addr, 8'h10);
    checkOutput("t1_mem_we_c1", mem_we, 0);
    checkOutput("t1_gnt_c1", {gnt0, gnt1}, 2'b10);
    checkOutput("t1_busy_c1", busy, 1);
    tick();
    checkOutput("t1_mem_en_c2", mem_en, 1);
    checkOutput("t1_mem_addr_c2", mem_addr, 8'h10);
    checkOutput("t1_ack_c2", ack0, 0);
    waitAck(6, cyc);
    checkOutput("t1_ack_latency", cyc, 1);
    checkOutput("t1_resp_mem_en", mem_en, 0);
    checkOutput("t1_resp_gnt", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    tick();
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_idle_ack", ack0, 0);

    // Single write on port 1; rdata1 must stay at its reset value
    applyStimulus(1'b1, 1'b1, 8'h20, 32'h12345678, 32'h0);
    tick();
    checkOutput("t2_mem_we_c1", {mem_en, mem_we}, 2'b11);
    checkOutput("t2_mem_wdata_c1", mem_wdata, 32'h12345678);
    checkOutput("t2_mem_addr_c1", mem_addr, 8'h20);
    checkOutput("t2_gnt_c1", {gnt0, gnt1}, 2'b01);
    tick();
    checkOutput("t2_mem_we_c2", {mem_en, mem_we}, 2'b11);
    checkOutput("t2_mem_wdata_c2", mem_wdata, 32'h12345678);
    waitAck(6, cyc);
    checkOutput("t2_ack_latency", cyc, 1);
    req1 = 1'b0; we1 = 1'b0;
    tick();

    // Both requests held after reset: 0,1,0,1 at 4-cycle spacing
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h30, 32'h0, mem_model(8'h30));
    applyStimulus(1'b1, 1'b0, 8'h40, 32'h0, mem_model(8'h40));
    sb.push_back('{port: 1'b0, data: mem_model(8'h30)});
    sb.push_back('{port: 1'b1, data: mem_model(8'h40)});
    waitAck(8, cyc);
    checkOutput("t3_first_latency", cyc, 3);
    for (int i = 0; i < 3; i++) begin
      waitAck(8, cyc);
      checkOutput("t3_ack_spacing", cyc, 4);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Address change while granted must not disturb the access
    applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    tick();
    addr0 = 8'hFF;
    checkOutput("t4_mem_addr_c1", mem_addr, 8'h10);
    tick();
    checkOutput("t4_mem_addr_c2", mem_addr, 8'h10);
    waitAck(6, cyc);
    checkOutput("t4_ack_latency", cyc, 1);
    req0 = 1'b0; addr0 = 8'h00;
    tick();

    // Reset during the first access cycle aborts the transfer
    applyStimulus(1'b0, 1'b0, 8'h44, 32'h0, 32'h0);
    void'(sb.pop_back());
    tick();
    checkOutput("t5_in_access", mem_en, 1);
    rst = 1'b1; req0 = 1'b0;
    tick();
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_mem_en", mem_en, 0);
    checkOutput("t5_ack", {ack0, ack1}, 0);
    checkOutput("t5_rdata", {rdata0, rdata1}, 0);
    checkOutput("t5_mem_addr", mem_addr, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 8'h40, 32'h0, mem_model(8'h40));
    tick();
    checkOutput("t5_tie_gnt", {gnt0, gnt1}, 2'b10);
    waitAck(6, cyc);
    checkOutput("t5_ack0_latency", cyc, 2);
    req0 = 1'b0;
    waitAck(8, cyc);
    checkOutput("t5_ack1_latency", cyc, 4);
    req1 = 1'b0;
    tick();

    // Request dropped early still completes with exactly one ack
    applyStimulus(1'b0, 1'b0, 8'h50, 32'h0, mem_model(8'h50));
    tick();
    req0 = 1'b0;
    waitAck(6, cyc);
    checkOutput("t6_ack_latency", cyc, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_no_extra_ack", {ack0, ack1}, 0);
      checkOutput("t6_idle_busy", busy, 0);
    end

    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
